// File: rtl/branch_predictor_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, reset and
// allocation counter values, PC increment, and the update control bundle.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    // Counters start weakly not-taken; a fresh allocation starts weakly taken.
    localparam cnt_e CNT_RST   = CNT_WNT;
    localparam cnt_e CNT_ALLOC = CNT_WT;

    localparam int unsigned PC_INC = 4;

    // Control part of a resolved-instruction update.
    typedef struct packed {
        logic is_br;
        logic is_jump;
        logic taken;
    } upd_ctl_t;

    // Saturating step of a 2-bit direction counter.
    function automatic cnt_e cnt_next(cnt_e c, logic taken);
        if (taken) return (c == CNT_ST)  ? CNT_ST  : cnt_e'(c + 2'd1);
        else       return (c == CNT_SNT) ? CNT_SNT : cnt_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// Predictor storage: ENTRIES-deep BTB with direction counters. One async read
// port for fetch lookup, one sync write port carrying the resolved outcome;
// the hit test and counter step for the written entry happen here.
module bp_table
    import branch_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_target,
    output logic             rd_jump,
    output logic             rd_cnt_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_target,
    input  upd_ctl_t         wr_ctl
);

    logic [ENTRIES-1:0] valid;
    logic [1:0]         cnt    [ENTRIES];
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [XLEN-1:0]    target [ENTRIES];
    logic               jump   [ENTRIES];

    logic wr_hit;
    logic wr_fill;

    assign rd_valid     = valid[rd_idx];
    assign rd_tag       = tag[rd_idx];
    assign rd_target    = target[rd_idx];
    assign rd_jump      = jump[rd_idx];
    assign rd_cnt_taken = cnt[rd_idx][1];

    // A hit refreshes the entry; a taken miss replaces whatever lives there.
    assign wr_hit  = valid[wr_idx] && (tag[wr_idx] == wr_tag);
    assign wr_fill = wr_en && (wr_hit || wr_ctl.taken);

    // Valid bits and direction counters: the only state that needs reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_RST;
        end else if (wr_en) begin
            if (wr_hit) begin
                if (wr_ctl.is_br) cnt[wr_idx] <= cnt_next(cnt_e'(cnt[wr_idx]), wr_ctl.taken);
            end else if (wr_ctl.taken) begin
                valid[wr_idx] <= 1'b1;
                cnt[wr_idx]   <= CNT_ALLOC;
            end
        end
    end

    // Tag/target/jump payload; unreset, hidden behind the valid bit.
    always_ff @(posedge clk) begin
        if (wr_fill && !rst) begin
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= wr_target;
            jump[wr_idx]   <= wr_ctl.is_jump;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch prediction unit: zero-latency fetch lookup into a tagged BTB with
// 2-bit counters, optional gshare history, registered mispredict/redirect
// and saturating statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int GHR_W   = 0,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pred_pc_i,
    output logic              pred_taken_o,
    output logic [XLEN-1:0]   pred_target_o,
    input  logic              upd_valid_i,
    input  logic [XLEN-1:0]   upd_pc_i,
    input  logic              upd_is_br_i,
    input  logic              upd_is_jump_i,
    input  logic              upd_taken_i,
    input  logic [XLEN-1:0]   upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [XLEN-1:0]   upd_pred_target_i,
    output logic              mispredict_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic [STAT_W-1:0] br_count_o,
    output logic [STAT_W-1:0] miss_count_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             rd_valid, rd_jump, rd_cnt_taken;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rd_target;
    logic             lk_hit;
    logic             upd_qual;
    logic [XLEN-1:0]  actual_pc, predicted_pc;
    logic             mis_next;
    upd_ctl_t         upd_ctl;
    logic             unused_pc_bits;

    // Only the index/tag slices of the PCs feed the tables.
    assign unused_pc_bits = ^{pred_pc_i, upd_pc_i};

    if (GHR_W > 0) begin : g_hist
        logic [GHR_W-1:0] ghr;
        // Committed-branch history; jumps are not direction information.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                              ghr <= '0;
            else if (upd_qual && upd_is_br_i)     ghr <= GHR_W'({ghr, upd_taken_i});
        end
        assign ghr_ext = IDX_W'(ghr);
    end else begin : g_bimodal
        assign ghr_ext = '0;
    end

    assign lk_idx = pred_pc_i[IDX_W+1:2] ^ ghr_ext;
    assign lk_tag = pred_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2] ^ ghr_ext;
    assign up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    assign upd_qual = upd_valid_i && (upd_is_br_i || upd_is_jump_i);
    assign upd_ctl  = '{is_br: upd_is_br_i, is_jump: upd_is_jump_i, taken: upd_taken_i};

    bp_table #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk          (clk),
        .rst          (rst),
        .rd_idx       (lk_idx),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_target    (rd_target),
        .rd_jump      (rd_jump),
        .rd_cnt_taken (rd_cnt_taken),
        .wr_en        (upd_qual),
        .wr_idx       (up_idx),
        .wr_tag       (up_tag),
        .wr_target    (upd_target_i),
        .wr_ctl       (upd_ctl)
    );

    assign lk_hit        = rd_valid && (rd_tag == lk_tag);
    assign pred_taken_o  = lk_hit && (rd_jump || rd_cnt_taken);
    assign pred_target_o = pred_taken_o ? rd_target : pred_pc_i + XLEN'(PC_INC);

    // Compare where the instruction really went against where fetch was sent.
    assign actual_pc    = upd_taken_i      ? upd_target_i      : upd_pc_i + XLEN'(PC_INC);
    assign predicted_pc = upd_pred_taken_i ? upd_pred_target_i : upd_pc_i + XLEN'(PC_INC);
    assign mis_next     = upd_qual && (actual_pc != predicted_pc);

    // Registered flush pulse, sticky redirect PC and saturating statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
            br_count_o    <= '0;
            miss_count_o  <= '0;
        end else begin
            mispredict_o <= mis_next;
            if (mis_next) redirect_pc_o <= actual_pc;
            if (upd_qual && (br_count_o != '1))   br_count_o   <= br_count_o + STAT_W'(1);
            if (mis_next && (miss_count_o != '1)) miss_count_o <= miss_count_o + STAT_W'(1);
        end
    end

endmodule
